// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: turns divider ticks into COUNT / SCAN / BLINK / FADE
// patterns on the board LEDs, all on the single system clock.
module led_pattern_seq #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned PWM_BITS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic [1:0]       mode_in,
    input  logic             pause_in,
    output logic [WIDTH-1:0] leds,
    output logic [1:0]       mode_out,
    output logic             pattern_wrap
);

    localparam int unsigned POS_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        MODE_COUNT = 2'd0,
        MODE_SCAN  = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_FADE  = 2'd3
    } mode_t;

    // Bit i set when i is even (0x55 for eight LEDs)
    function automatic logic [WIDTH-1:0] even_bits();
        logic [WIDTH-1:0] p;
        p = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            p[i] = ((i % 2) == 0);
        end
        return p;
    endfunction

    localparam logic [WIDTH-1:0]    EVEN_PAT = even_bits();
    localparam logic [PWM_BITS-1:0] DUTY_MAX = '1;
    localparam logic [POS_W-1:0]    POS_MAX  = POS_W'(WIDTH - 1);

    mode_t               mode_q,    mode_d;
    logic [WIDTH-1:0]    count_q,   count_d;
    logic [POS_W-1:0]    pos_q,     pos_d;
    logic                scan_dn_q, scan_dn_d;
    logic                phase_q,   phase_d;
    logic [PWM_BITS-1:0] duty_q,    duty_d;
    logic                duty_dn_q, duty_dn_d;
    logic [PWM_BITS-1:0] pwm_q;
    logic [WIDTH-1:0]    leds_d;
    logic                wrap_d;
    logic                step;

    assign step = tick_in & ~pause_in;

    // Step evaluation: mode switch loads start state, otherwise advance active mode
    always_comb begin
        mode_d    = mode_q;
        count_d   = count_q;
        pos_d     = pos_q;
        scan_dn_d = scan_dn_q;
        phase_d   = phase_q;
        duty_d    = duty_q;
        duty_dn_d = duty_dn_q;
        wrap_d    = 1'b0;

        if (step) begin
            if (mode_t'(mode_in) != mode_q) begin
                mode_d = mode_t'(mode_in);
                case (mode_t'(mode_in))
                    MODE_COUNT: count_d = '0;
                    MODE_SCAN: begin
                        pos_d     = '0;
                        scan_dn_d = 1'b0;
                    end
                    MODE_BLINK: phase_d = 1'b0;
                    MODE_FADE: begin
                        duty_d    = '0;
                        duty_dn_d = 1'b0;
                    end
                    default: ;
                endcase
            end else begin
                case (mode_q)
                    MODE_COUNT: begin
                        count_d = count_q + WIDTH'(1);
                        wrap_d  = (count_q == '1);
                    end
                    MODE_SCAN: begin
                        if (!scan_dn_q) begin
                            pos_d = pos_q + POS_W'(1);
                            if (pos_d == POS_MAX) scan_dn_d = 1'b1;
                        end else begin
                            pos_d = pos_q - POS_W'(1);
                            if (pos_d == '0) begin
                                scan_dn_d = 1'b0;
                                wrap_d    = 1'b1;
                            end
                        end
                    end
                    MODE_BLINK: begin
                        phase_d = ~phase_q;
                        wrap_d  = phase_q;
                    end
                    MODE_FADE: begin
                        if (!duty_dn_q) begin
                            duty_d = duty_q + PWM_BITS'(1);
                            if (duty_d == DUTY_MAX) duty_dn_d = 1'b1;
                        end else begin
                            duty_d = duty_q - PWM_BITS'(1);
                            if (duty_d == '0) begin
                                duty_dn_d = 1'b0;
                                wrap_d    = 1'b1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // LED pattern for the (possibly new) mode; FADE re-evaluates its PWM compare every cycle
    always_comb begin
        leds_d = '0;
        case (mode_d)
            MODE_COUNT: leds_d = count_d;
            MODE_SCAN:  leds_d = WIDTH'(1) << pos_d;
            MODE_BLINK: leds_d = phase_d ? ~EVEN_PAT : EVEN_PAT;
            MODE_FADE:  leds_d = {WIDTH{pwm_q < duty_d}};
            default:    leds_d = '0;
        endcase
    end

    // State and output registers; the PWM counter free-runs even while paused
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q       <= MODE_COUNT;
            count_q      <= '0;
            pos_q        <= '0;
            scan_dn_q    <= 1'b0;
            phase_q      <= 1'b0;
            duty_q       <= '0;
            duty_dn_q    <= 1'b0;
            pwm_q        <= '0;
            leds         <= '0;
            pattern_wrap <= 1'b0;
        end else begin
            mode_q       <= mode_d;
            count_q      <= count_d;
            pos_q        <= pos_d;
            scan_dn_q    <= scan_dn_d;
            phase_q      <= phase_d;
            duty_q       <= duty_d;
            duty_dn_q    <= duty_dn_d;
            pwm_q        <= pwm_q + PWM_BITS'(1);
            leds         <= leds_d;
            pattern_wrap <= wrap_d;
        end
    end

    assign mode_out = mode_q;

endmodule
